// File: rtl/cpu_memreq.sv
// Load/store request issuer: formats execute-stage memory ops, queues them and issues them to DCACHE or AUX.
// Optional statistics counters are enabled with `define CPU_MEMREQ_STATS_EN.
module cpu_memreq #(
   parameter logic [15:0] AUX_BASE        = 16'hE000,
   parameter int unsigned MAX_OUTSTANDING = 3
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_write,
   input  logic [1:0]  ex_size,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   input  logic [4:0]  ex_dest,
   output logic        cpu_dcache_req,
   input  logic        cpu_dcache_ready,
   output logic        cpu_dcache_write,
   output logic [31:0] cpu_dcache_addr,
   output logic [3:0]  cpu_dcache_wmask,
   output logic [31:0] cpu_dcache_wdata,
   output logic [8:0]  cpu_dcache_tag,
   output logic        cpu_aux_req,
   input  logic        cpu_aux_ready,
   output logic        cpu_aux_write,
   output logic [31:0] cpu_aux_addr,
   output logic [3:0]  cpu_aux_wmask,
   output logic [31:0] cpu_aux_wdata,
   output logic [8:0]  cpu_aux_tag,
   input  logic        cpu_dcache_rvalid,
   input  logic        cpu_aux_rvalid,
   output logic        misalign_exc,
   output logic [31:0] misalign_addr,
   output logic [31:0] stat_reads,
   output logic [31:0] stat_writes,
   output logic [31:0] stat_stalls
);

   localparam int unsigned OUT_W = 3;
   localparam int unsigned CNT_W = 2;

   typedef struct packed {
      logic        aux;
      logic        write;
      logic [29:0] waddr;
      logic [3:0]  wmask;
      logic [31:0] wdata;
      logic [8:0]  tag;
   } req_t;

   req_t             head_q, head_d, tail_q, tail_d, new_c;
   logic [CNT_W-1:0] count_q, count_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic             misalign_exc_q;
   logic [31:0]      misalign_addr_q;

   logic [3:0]  fmt_c, mask_c;
   logic [31:0] wdata_c;
   logic        misalign_c, accept_c, push_c, pop_c, load_issue_c, issue_ok_c, underflow_c;
   logic [1:0]  dec_c;
   logic [3:0]  sum_c;

   // Op decode: lane format, byte enables, replicated store data, alignment check
   always_comb begin
      fmt_c      = 4'b0000;
      mask_c     = 4'b0000;
      wdata_c    = ex_wdata;
      misalign_c = 1'b0;
      case (ex_size)
         2'd0: begin
            fmt_c   = {2'b00, ex_addr[1:0]};
            mask_c  = 4'b0001 << ex_addr[1:0];
            wdata_c = {4{ex_wdata[7:0]}};
         end
         2'd1: begin
            fmt_c      = {2'b01, ex_addr[1], 1'b0};
            mask_c     = 4'b0011 << ex_addr[1:0];
            wdata_c    = {2{ex_wdata[15:0]}};
            misalign_c = ex_addr[0];
         end
         2'd2: begin
            fmt_c      = 4'b1000;
            mask_c     = 4'b1111;
            misalign_c = |ex_addr[1:0];
         end
         default: misalign_c = 1'b1;
      endcase
   end

   always_comb begin
      new_c.aux   = (ex_addr[31:16] == AUX_BASE);
      new_c.write = ex_write;
      new_c.waddr = ex_addr[31:2];
      new_c.wmask = mask_c;
      new_c.wdata = wdata_c;
      new_c.tag   = {fmt_c, ex_write ? 5'b00000 : ex_dest};
   end

   assign ex_ready     = (count_q < CNT_W'(2));
   assign accept_c     = ex_valid & ex_ready;
   assign push_c       = accept_c & ~misalign_c;
   // Loads wait at the head while the response path is full; stores always go
   assign issue_ok_c   = (count_q != '0) &
                         ~(~head_q.write & (out_q == OUT_W'(MAX_OUTSTANDING)));
   assign cpu_dcache_req = issue_ok_c & ~head_q.aux;
   assign cpu_aux_req    = issue_ok_c &  head_q.aux;
   assign pop_c        = (cpu_dcache_req & cpu_dcache_ready) | (cpu_aux_req & cpu_aux_ready);
   assign load_issue_c = pop_c & ~head_q.write;

   assign cpu_dcache_write = head_q.write;
   assign cpu_dcache_addr  = {head_q.waddr, 2'b00};
   assign cpu_dcache_wmask = head_q.wmask;
   assign cpu_dcache_wdata = head_q.wdata;
   assign cpu_dcache_tag   = head_q.tag;
   assign cpu_aux_write    = head_q.write;
   assign cpu_aux_addr     = {head_q.waddr, 2'b00};
   assign cpu_aux_wmask    = head_q.wmask;
   assign cpu_aux_wdata    = head_q.wdata;
   assign cpu_aux_tag      = head_q.tag;
   assign misalign_exc     = misalign_exc_q;
   assign misalign_addr    = misalign_addr_q;

   // Two-entry queue; a same-cycle push and pop only happens at count 1
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({push_c, pop_c})
         2'b10: begin
            if (count_q == '0) head_d = new_c;
            else               tail_d = new_c;
            count_d = count_q + CNT_W'(1);
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - CNT_W'(1);
         end
         2'b11:   head_d = new_c;
         default: ;
      endcase
   end

   // Outstanding reads: net of one issue and up to two retirements, floored at 0
   always_comb begin
      dec_c       = {1'b0, cpu_dcache_rvalid} + {1'b0, cpu_aux_rvalid};
      sum_c       = {1'b0, out_q} + {3'b000, load_issue_c};
      underflow_c = (sum_c < {2'b00, dec_c});
      out_d       = underflow_c ? '0 : OUT_W'(sum_c - {2'b00, dec_c});
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_q          <= '0;
         tail_q          <= '0;
         count_q         <= '0;
         out_q           <= '0;
         misalign_exc_q  <= 1'b0;
         misalign_addr_q <= '0;
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         out_q          <= out_d;
         misalign_exc_q <= accept_c & misalign_c;
         if (accept_c & misalign_c) misalign_addr_q <= ex_addr;
      end
   end

   a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n) !underflow_c);

`ifdef CPU_MEMREQ_STATS_EN
   logic [31:0] reads_q, writes_q, stalls_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         reads_q  <= '0;
         writes_q <= '0;
         stalls_q <= '0;
      end else begin
         reads_q  <= reads_q  + 32'(load_issue_c);
         writes_q <= writes_q + 32'(pop_c & head_q.write);
         stalls_q <= stalls_q + 32'(ex_valid & ~ex_ready);
      end
   end

   assign stat_reads  = reads_q;
   assign stat_writes = writes_q;
   assign stat_stalls = stalls_q;
`else
   assign stat_reads  = '0;
   assign stat_writes = '0;
   assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_cpu_memreq.sv
// Directed self-checking bench for cpu_memreq (default parameters, MAX_OUTSTANDING=3).
module tb_cpu_memreq;

   logic        clock, reset_n;
   logic        ex_valid, ex_ready, ex_write;
   logic [1:0]  ex_size;
   logic [31:0] ex_addr, ex_wdata;
   logic [4:0]  ex_dest;
   logic        cpu_dcache_req, cpu_dcache_ready, cpu_dcache_write;
   logic [31:0] cpu_dcache_addr, cpu_dcache_wdata;
   logic [3:0]  cpu_dcache_wmask;
   logic [8:0]  cpu_dcache_tag;
   logic        cpu_aux_req, cpu_aux_ready, cpu_aux_write;
   logic [31:0] cpu_aux_addr, cpu_aux_wdata;
   logic [3:0]  cpu_aux_wmask;
   logic [8:0]  cpu_aux_tag;
   logic        cpu_dcache_rvalid, cpu_aux_rvalid;
   logic        misalign_exc;
   logic [31:0] misalign_addr, stat_reads, stat_writes, stat_stalls;

   int n_checks = 0;
   int n_errors = 0;

   cpu_memreq dut (
      .clock(clock), .reset_n(reset_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_write(ex_write), .ex_size(ex_size),
      .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_dest(ex_dest),
      .cpu_dcache_req(cpu_dcache_req), .cpu_dcache_ready(cpu_dcache_ready),
      .cpu_dcache_write(cpu_dcache_write), .cpu_dcache_addr(cpu_dcache_addr),
      .cpu_dcache_wmask(cpu_dcache_wmask), .cpu_dcache_wdata(cpu_dcache_wdata),
      .cpu_dcache_tag(cpu_dcache_tag),
      .cpu_aux_req(cpu_aux_req), .cpu_aux_ready(cpu_aux_ready),
      .cpu_aux_write(cpu_aux_write), .cpu_aux_addr(cpu_aux_addr),
      .cpu_aux_wmask(cpu_aux_wmask), .cpu_aux_wdata(cpu_aux_wdata),
      .cpu_aux_tag(cpu_aux_tag),
      .cpu_dcache_rvalid(cpu_dcache_rvalid), .cpu_aux_rvalid(cpu_aux_rvalid),
      .misalign_exc(misalign_exc), .misalign_addr(misalign_addr),
      .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_stalls(stat_stalls)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_op(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] d);
      ex_valid = 1'b1; ex_write = wr; ex_size = sz; ex_addr = a; ex_wdata = wd; ex_dest = d;
   endtask

   initial begin
      reset_n = 1'b0; ex_valid = 1'b0; ex_write = 1'b0; ex_size = 2'd0;
      ex_addr = '0; ex_wdata = '0; ex_dest = '0;
      cpu_dcache_ready = 1'b1; cpu_aux_ready = 1'b1;
      cpu_dcache_rvalid = 1'b0; cpu_aux_rvalid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_eq("rst_ready", ex_ready, 1);
      check_eq("rst_dreq", cpu_dcache_req, 0);
      check_eq("rst_areq", cpu_aux_req, 0);
      check_eq("rst_exc", misalign_exc, 0);
      check_eq("rst_addr", cpu_dcache_addr, 0);
      check_eq("rst_tag", cpu_dcache_tag, 0);
      reset_n = 1'b1;
      tick();

      // 1: load byte from 0x1003 into r7
      set_op(1'b0, 2'd0, 32'h0000_1003, 32'h0, 5'd7);
      tick();
      ex_valid = 1'b0;
      check_eq("t1_dreq", cpu_dcache_req, 1);
      check_eq("t1_areq", cpu_aux_req, 0);
      check_eq("t1_addr", cpu_dcache_addr, 32'h0000_1000);
      check_eq("t1_tag", cpu_dcache_tag, 32'h067);
      check_eq("t1_mask", cpu_dcache_wmask, 32'h8);
      check_eq("t1_write", cpu_dcache_write, 0);
      tick();
      cpu_dcache_rvalid = 1'b1;
      tick();
      cpu_dcache_rvalid = 1'b0;

      // 2: store half to AUX region
      set_op(1'b1, 2'd1, 32'hE000_0006, 32'h1234_ABCD, 5'd9);
      tick();
      ex_valid = 1'b0;
      check_eq("t2_areq", cpu_aux_req, 1);
      check_eq("t2_dreq", cpu_dcache_req, 0);
      check_eq("t2_addr", cpu_aux_addr, 32'hE000_0004);
      check_eq("t2_wdata", cpu_aux_wdata, 32'hABCD_ABCD);
      check_eq("t2_mask", cpu_aux_wmask, 32'hC);
      check_eq("t2_tag", cpu_aux_tag, 32'h0C0);
      check_eq("t2_write", cpu_aux_write, 1);
      tick();
      check_eq("t2_popped", cpu_aux_req, 0);

      // 3: five word loads against a cap of three outstanding reads
      for (int i = 0; i < 4; i++) begin
         set_op(1'b0, 2'd2, 32'h100 + 32'(4 * i), 32'h0, 5'(i + 1));
         tick();
      end
      check_eq("t3_held", cpu_dcache_req, 0);
      check_eq("t3_head", cpu_dcache_addr, 32'h10C);
      check_eq("t3_rdy1", ex_ready, 1);
      set_op(1'b0, 2'd2, 32'h110, 32'h0, 5'd5);
      tick();
      ex_valid = 1'b0;
      check_eq("t3_full", ex_ready, 0);
      check_eq("t3_held2", cpu_dcache_req, 0);
      cpu_dcache_rvalid = 1'b1;
      tick();
      cpu_dcache_rvalid = 1'b0;
      check_eq("t3_rel", cpu_dcache_req, 1);
      check_eq("t3_rel_tag", cpu_dcache_tag, 32'h104);
      tick();
      check_eq("t3_held3", cpu_dcache_req, 0);
      check_eq("t3_head5", cpu_dcache_addr, 32'h110);
      check_eq("t3_rdy2", ex_ready, 1);
      cpu_dcache_rvalid = 1'b1; cpu_aux_rvalid = 1'b1;
      tick();
      cpu_dcache_rvalid = 1'b0; cpu_aux_rvalid = 1'b0;
      check_eq("t3_dual_ret", cpu_dcache_req, 1);
      tick();
      check_eq("t3_empty", cpu_dcache_req, 0);
      cpu_dcache_rvalid = 1'b1; cpu_aux_rvalid = 1'b1;
      tick();
      cpu_dcache_rvalid = 1'b0; cpu_aux_rvalid = 1'b0;

      // 4: misaligned word load, then a normal byte store
      set_op(1'b0, 2'd2, 32'h0000_2002, 32'h0, 5'd3);
      tick();
      ex_valid = 1'b0;
      check_eq("t4_exc", misalign_exc, 1);
      check_eq("t4_maddr", misalign_addr, 32'h2002);
      check_eq("t4_noreq", cpu_dcache_req, 0);
      set_op(1'b1, 2'd0, 32'h0000_3001, 32'h0000_0055, 5'd4);
      tick();
      ex_valid = 1'b0;
      check_eq("t4_exc_pulse", misalign_exc, 0);
      check_eq("t4_req", cpu_dcache_req, 1);
      check_eq("t4_wdata", cpu_dcache_wdata, 32'h5555_5555);
      check_eq("t4_mask", cpu_dcache_wmask, 32'h2);
      check_eq("t4_tag", cpu_dcache_tag, 32'h020);
      tick();

      // 5: backpressured store must hold its payload
      cpu_dcache_ready = 1'b0;
      set_op(1'b1, 2'd2, 32'h0000_4000, 32'hDEAD_BEEF, 5'd0);
      tick();
      ex_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_eq("t5_req", cpu_dcache_req, 1);
         check_eq("t5_addr", cpu_dcache_addr, 32'h4000);
         check_eq("t5_wdata", cpu_dcache_wdata, 32'hDEAD_BEEF);
         check_eq("t5_mask", cpu_dcache_wmask, 32'hF);
         check_eq("t5_tag", cpu_dcache_tag, 32'h100);
         tick();
      end
      cpu_dcache_ready = 1'b1;
      check_eq("t5_req_last", cpu_dcache_req, 1);
      tick();
      check_eq("t5_popped", cpu_dcache_req, 0);

      // 6: reset with two queued requests and two reads outstanding
      cpu_dcache_ready = 1'b1;
      set_op(1'b0, 2'd2, 32'h500, 32'h0, 5'd1);
      tick();
      set_op(1'b0, 2'd2, 32'h504, 32'h0, 5'd2);
      tick();
      ex_valid = 1'b0;
      tick();
      cpu_dcache_ready = 1'b0;
      set_op(1'b1, 2'd2, 32'h600, 32'h1, 5'd0);
      tick();
      set_op(1'b0, 2'd2, 32'h604, 32'h0, 5'd3);
      tick();
      ex_valid = 1'b0;
      check_eq("t6_full", ex_ready, 0);
      check_eq("t6_req", cpu_dcache_req, 1);
`ifdef CPU_MEMREQ_STATS_EN
      check_eq("t6_reads", stat_reads, 8);
      check_eq("t6_writes", stat_writes, 3);
      check_eq("t6_stalls", stat_stalls, 0);
`endif
      #1 reset_n = 1'b0;
      #1;
      check_eq("t6_rst_req", cpu_dcache_req, 0);
      check_eq("t6_rst_maddr", misalign_addr, 0);
      check_eq("t6_rst_reads", stat_reads, 0);
      check_eq("t6_rst_writes", stat_writes, 0);
      #2 reset_n = 1'b1;
      cpu_dcache_ready = 1'b1;
      tick();
      check_eq("t6_ready", ex_ready, 1);
      set_op(1'b0, 2'd2, 32'h700, 32'h0, 5'd1);
      tick();
      set_op(1'b0, 2'd2, 32'h704, 32'h0, 5'd2);
      tick();
      ex_valid = 1'b0;
      check_eq("t6_out_clr", cpu_dcache_req, 1);
      tick();
      cpu_dcache_rvalid = 1'b1; cpu_aux_rvalid = 1'b1;
      tick();
      cpu_dcache_rvalid = 1'b0; cpu_aux_rvalid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
